// File: rtl/seq_split_multiplier_if.sv
// Valid/ready handshake bundle for seq_split_multiplier: operand/mode request
// channel plus product response channel.
interface seq_split_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               approx;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               p_approx;

  modport master (
    output in_valid, a, b, approx, out_ready,
    input  in_ready, out_valid, p, p_approx
  );

  modport slave (
    input  in_valid, a, b, approx, out_ready,
    output in_ready, out_valid, p, p_approx
  );
endinterface

// File: rtl/seq_split_multiplier.sv
// Iterative split-operand unsigned multiplier: HH, HL, LH, LL partial products
// on one shared sub-multiplier, with an approximate mode that drops LL.
module seq_split_multiplier #(
  parameter int WIDTH = 8,
  parameter int SPLIT = 2,
  parameter int TRUNC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_split_multiplier_if.slave bus,
  output logic                 busy
);
  localparam int HW = WIDTH - SPLIT;

  typedef enum logic [2:0] {IDLE, HH, HL, LH, LL, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               approx_r;
  logic [2*WIDTH-1:0] acc;

  logic [HW-1:0]      ah, bh, al_x, bl_x;
  logic [HW-1:0]      mx, my;
  logic [2*HW-1:0]    prod;
  logic [2*HW-1:0]    tmask;
  logic [2*HW-1:0]    tprod;
  logic [2*WIDTH-1:0] term;
  logic [2*WIDTH-1:0] sum;

  assign ah   = a_r[WIDTH-1:SPLIT];
  assign bh   = b_r[WIDTH-1:SPLIT];
  assign al_x = HW'(a_r[SPLIT-1:0]);
  assign bl_x = HW'(b_r[SPLIT-1:0]);

  always_comb begin
    mx = ah;
    my = bh;
    case (state)
      HL:      my = bl_x;
      LH:      mx = al_x;
      LL: begin
        mx = al_x;
        my = bl_x;
      end
      default: ;
    endcase
  end

  assign prod = (2*HW)'(mx) * (2*HW)'(my);

  always_comb begin
    tmask = '1;
    for (int unsigned i = 0; i < 2*HW; i++)
      tmask[i] = (i >= TRUNC);
  end

  // Truncation only ever applies to the cross terms
  assign tprod = (approx_r && (state == HL || state == LH)) ? (prod & tmask) : prod;

  always_comb begin
    term = (2*WIDTH)'(tprod);
    case (state)
      HH:      term = (2*WIDTH)'(tprod) << (2*SPLIT);
      HL, LH:  term = (2*WIDTH)'(tprod) << SPLIT;
      default: ;
    endcase
  end

  assign sum = acc + term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      a_r           <= '0;
      b_r           <= '0;
      approx_r      <= 1'b0;
      acc           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.p         <= '0;
      bus.p_approx  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r          <= bus.a;
            b_r          <= bus.b;
            approx_r     <= bus.approx;
            acc          <= '0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= HH;
          end
        end
        HH: begin
          acc   <= sum;
          state <= HL;
        end
        HL: begin
          acc   <= sum;
          state <= LH;
        end
        LH: begin
          acc <= sum;
          if (approx_r) begin
            bus.p         <= sum;
            bus.p_approx  <= 1'b1;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            state <= LL;
          end
        end
        LL: begin
          acc           <= sum;
          bus.p         <= sum;
          bus.p_approx  <= approx_r;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
